pipe_trace_buffer: RTL



---
 rtl/pipe_trace_buffer_if.sv | 41 ++++
 rtl/pipe_trace_buffer.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/pipe_trace_buffer_if.sv
`timescale 1ns/1ps
// Tap and readout bundle for pipe_trace_buffer: capture tuple, trigger control, status and
// the oldest-first read port. master drives the taps/controls, slave is the trace buffer.
interface pipe_trace_buffer_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned TS_W  = 16
);
  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  logic            cap_valid;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] instr;
  logic [XLEN-1:0] result;
  logic            arm;
  logic            trig_en;
  logic [XLEN-1:0] trig_pc;
  logic            force_trig;
  logic            rd_en;

  logic [1:0]      state;
  logic            triggered;
  logic            done;
  logic [CntW-1:0] count;
  logic            rd_valid;
  logic [XLEN-1:0] rd_pc;
  logic [XLEN-1:0] rd_instr;
  logic [XLEN-1:0] rd_result;
  logic            rd_last;
  logic [TS_W-1:0] rd_ts;

  modport master (
    output cap_valid, pc, instr, result, arm, trig_en, trig_pc, force_trig, rd_en,
    input  state, triggered, done, count, rd_valid, rd_pc, rd_instr, rd_result, rd_last, rd_ts
  );

  modport slave (
    input  cap_valid, pc, instr, result, arm, trig_en, trig_pc, force_trig, rd_en,
    output state, triggered, done, count, rd_valid, rd_pc, rd_instr, rd_result, rd_last, rd_ts
  );
endinterface

// File: rtl/pipe_trace_buffer.sv
`timescale 1ns/1ps
// Circular trace buffer of retired (pc, instr, result) tuples with PC/forced trigger and
// oldest-first readout. Define TRACE_TIMESTAMP_EN to store a free-running cycle stamp per entry.
module pipe_trace_buffer #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned POST_TRIG = 4,
  parameter int unsigned TS_W      = 16
) (
  input logic                clk,
  input logic                rst,
  pipe_trace_buffer_if.slave bus
);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] DepthC = CntW'(DEPTH);
  localparam logic [CntW-1:0] PostC  = CntW'(POST_TRIG);

  typedef enum logic [1:0] {StIdle = 2'd0, StArmed = 2'd1, StPost = 2'd2, StDone = 2'd3} state_e;

  state_e          state_q, state_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d, post_q, post_d, rd_left_q, rd_left_d;
  logic            trig_q, trig_d, rd_valid_q, rd_valid_d, rd_last_q, rd_last_d;
  logic [XLEN-1:0] rd_pc_q, rd_pc_d, rd_instr_q, rd_instr_d, rd_result_q, rd_result_d;
  logic            wr_en, rd_fire, hit, go_done;

  logic [XLEN-1:0] mem_pc_q     [DEPTH];
  logic [XLEN-1:0] mem_instr_q  [DEPTH];
  logic [XLEN-1:0] mem_result_q [DEPTH];

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    post_d     = post_q;
    rd_left_d  = rd_left_q;
    trig_d     = trig_q;
    rd_valid_d = 1'b0;
    rd_last_d  = 1'b0;
    wr_en      = 1'b0;
    rd_fire    = 1'b0;
    go_done    = 1'b0;
    hit        = bus.force_trig || (bus.trig_en && bus.cap_valid && (bus.pc == bus.trig_pc));

    unique case (state_q)
      StArmed: begin
        wr_en = bus.cap_valid;
        if (hit) begin
          trig_d = 1'b1;
          if (POST_TRIG == 0) go_done = 1'b1;
          else                state_d = StPost;
        end
      end
      StPost: begin
        if (bus.cap_valid) begin
          wr_en  = 1'b1;
          post_d = post_q + CntW'(1);
          if (post_d == PostC) go_done = 1'b1;
        end
      end
      StIdle, StDone: begin
        // arm takes priority over a same-cycle read, which is simply dropped
        if (bus.arm) begin
          state_d  = StArmed;
          wr_ptr_d = '0;
          count_d  = '0;
          post_d   = '0;
          trig_d   = 1'b0;
        end else if (state_q == StDone && bus.rd_en && rd_left_q != '0) begin
          rd_fire    = 1'b1;
          rd_valid_d = 1'b1;
          rd_last_d  = (rd_left_q == CntW'(1));
          rd_ptr_d   = rd_ptr_q + PtrW'(1);
          rd_left_d  = rd_left_q - CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (count_q != DepthC) count_d = count_q + CntW'(1);
    end

    // Once the buffer has wrapped, the oldest entry sits at the next write slot
    if (go_done) begin
      state_d   = StDone;
      rd_left_d = count_d;
      rd_ptr_d  = (count_d == DepthC) ? wr_ptr_d : '0;
    end

    rd_pc_d     = rd_fire ? mem_pc_q[rd_ptr_q]     : rd_pc_q;
    rd_instr_d  = rd_fire ? mem_instr_q[rd_ptr_q]  : rd_instr_q;
    rd_result_d = rd_fire ? mem_result_q[rd_ptr_q] : rd_result_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      post_q      <= '0;
      rd_left_q   <= '0;
      trig_q      <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_last_q   <= 1'b0;
      rd_pc_q     <= '0;
      rd_instr_q  <= '0;
      rd_result_q <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      post_q      <= post_d;
      rd_left_q   <= rd_left_d;
      trig_q      <= trig_d;
      rd_valid_q  <= rd_valid_d;
      rd_last_q   <= rd_last_d;
      rd_pc_q     <= rd_pc_d;
      rd_instr_q  <= rd_instr_d;
      rd_result_q <= rd_result_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_pc_q[wr_ptr_q]     <= bus.pc;
      mem_instr_q[wr_ptr_q]  <= bus.instr;
      mem_result_q[wr_ptr_q] <= bus.result;
    end
  end

`ifdef TRACE_TIMESTAMP_EN
  logic [TS_W-1:0] ts_q, ts_d, rd_ts_q, rd_ts_d;
  logic [TS_W-1:0] mem_ts_q [DEPTH];

  always_comb begin
    ts_d    = ts_q + TS_W'(1);
    rd_ts_d = rd_fire ? mem_ts_q[rd_ptr_q] : rd_ts_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ts_q    <= '0;
      rd_ts_q <= '0;
    end else begin
      ts_q    <= ts_d;
      rd_ts_q <= rd_ts_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_ts_q[wr_ptr_q] <= ts_q;
  end

  assign bus.rd_ts = rd_ts_q;
`else
  assign bus.rd_ts = {TS_W{1'b0}};
`endif

  assign bus.state     = state_q;
  assign bus.triggered = trig_q;
  assign bus.done      = (state_q == StDone);
  assign bus.count     = count_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.rd_last   = rd_last_q;
  assign bus.rd_pc     = rd_pc_q;
  assign bus.rd_instr  = rd_instr_q;
  assign bus.rd_result = rd_result_q;
endmodule
